// File: rtl/mux_sel_pipe_pkg.sv
// Shared definitions for mux_sel_pipe: channel-select mode encoding and
// the index-width helper used to size sel / out_chan / last_grant.
package mux_sel_pipe_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search for mux_sel_pipe: grants the first
// requesting channel found upward from last_grant+1, wrapping at NCH.
module rr_arbiter
    import mux_sel_pipe_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned IW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last_grant,
    output logic           grant_valid,
    output logic [IW-1:0]  grant_idx
);

    // Visit channels in priority order (offset 1..NCH from last_grant); first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!grant_valid && req[i] &&
                    (i == ((int'(last_grant) + k) % NCH))) begin
                    grant_valid = 1'b1;
                    grant_idx   = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-channel valid/ready multiplexer with one output register stage.
// Channel chosen either by a fixed sel input or by round-robin.
// Optional feature: define MUX_SEL_PIPE_PARITY_EN to add out_parity,
// the registered XOR of out_data.
module mux_sel_pipe
    import mux_sel_pipe_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned IW   = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [IW-1:0]        sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [IW-1:0]        out_chan,
`ifdef MUX_SEL_PIPE_PARITY_EN
    output logic                 out_parity,
`endif
    input  logic                 out_ready
);

    mode_e            mode_sel;
    logic             load;
    logic             accept;
    logic             rr_valid;
    logic [IW-1:0]    rr_idx;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IW-1:0]    out_chan_q,  out_chan_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;

    assign mode_sel = mode_e'(mode);
    assign load     = !out_valid_q || out_ready;
    assign accept   = load && grant_valid && !rst;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (last_grant_q),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Pick the granted channel: arbiter result in RR mode, sel in fixed mode
    // (a sel with no matching channel grants nothing).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode_sel == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == IW'(i)) begin
                    grant_valid = in_valid[i];
                    grant_idx   = sel;
                end
            end
        end
    end

    // One-hot accept to the granted channel plus its data slice.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx == IW'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage refills whenever it is empty or draining; data holds on an empty load.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                if (mode_sel == MODE_RR) begin
                    last_grant_d = grant_idx;
                end
            end
        end
    end

    // State registers; last_grant resets to NCH-1 so the first RR search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= IW'(NCH - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef MUX_SEL_PIPE_PARITY_EN
    logic parity_q, parity_d;

    // Parity captured in the same load as out_data.
    always_comb begin
        parity_d = parity_q;
        if (load && grant_valid) begin
            parity_d = ^grant_data;
        end
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule
